// File: rtl/sram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arbiter_pkg
//   Shared definitions for the instruction/data SRAM-port arbiter:
//   source identifiers stored in the ordering FIFO and the grant FSM states.
// ----------------------------------------------------------------------------
package sram_arbiter_pkg;

    // Source id recorded per accepted request, used to route the response.
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Grant FSM: IDLE has no locked grant; HOLD_x keeps x on the port
    // until the slave accepts it.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_arbiter_order_fifo.sv
// ----------------------------------------------------------------------------
// arb_order_fifo
//   1-bit-wide synchronous FIFO holding the source id of every accepted
//   request in issue order. Pointers wrap modulo MAX_OUTSTANDING (power of 2).
//   Push while full and pop while empty are ignored.
//
// Ports:
//   clk       clock
//   resetn    asynchronous active-low reset (contents discarded)
//   push      write push_src at the tail
//   push_src  source id to store
//   pop       drop the head entry
//   head_src  source id at the head
//   count     number of stored entries (0..MAX_OUTSTANDING)
//   full      count == MAX_OUTSTANDING
//   empty     count == 0
// ----------------------------------------------------------------------------
module arb_order_fifo #(
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned PTR_W           = $clog2(MAX_OUTSTANDING)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             push_src,
    input  logic             pop,
    output logic             head_src,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] slots;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic                       do_push;
    logic                       do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_src = slots[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_src;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
//   2:1 arbiter sharing one SRAM-like memory port between the instruction
//   master (IF) and the data master (EX/MEM). Accepted requests are recorded
//   in issue order; each in-order slave response is routed back to the master
//   that issued it. No added latency on request or response paths.
//
// Configuration:
//   SRAM_ARB_RR_EN  defined   : round-robin between masters (last_grant reg)
//                   undefined : fixed priority, data over inst
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   inst_* / data_* (in)             master request: en, wr, size, wen,
//                                    addr, wdata
//   inst_addr_ok / data_addr_ok      request accepted this cycle
//   inst_data_ok / data_data_ok      response for this master this cycle
//   inst_rdata / data_rdata          mem_rdata broadcast to both masters
//   mem_en, mem_wr, mem_size,
//   mem_wen, mem_addr, mem_wdata     request to the slave
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                        slave handshake and read data
// ----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_en,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wen,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_en,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    arb_state_e      state;
    arb_state_e      next_state;
    logic            grant_valid;
    logic            grant_src;
    logic            winner;
    logic            accept;
    logic            resp;
    logic            ord_head;
    logic            ord_full;
    logic            ord_empty;
    // Occupancy is only needed inside the FIFO; full/empty drive decisions here.
    logic [PTR_W:0]  unused_ord_count;

    // ---------------- winner selection (IDLE only) ----------------
`ifdef SRAM_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= SRC_INST;
        end else if (accept) begin
            last_grant <= grant_src;
        end
    end

    always_comb begin
        winner = SRC_INST;
        if (inst_en && data_en) begin
            winner = ~last_grant;
        end else if (data_en) begin
            winner = SRC_DATA;
        end
    end
`else
    always_comb begin
        winner = data_en ? SRC_DATA : SRC_INST;
    end
`endif

    // ---------------- grant FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        grant_valid = 1'b0;
        grant_src   = SRC_INST;
        unique case (state)
            ARB_IDLE: begin
                if (!ord_full && (inst_en || data_en)) begin
                    grant_valid = 1'b1;
                    grant_src   = winner;
                    if (!mem_addr_ok) begin
                        next_state = (winner == SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
                    end
                end
            end
            ARB_HOLD_I: begin
                grant_src = SRC_INST;
                // A full FIFO suppresses mem_en but keeps the locked grant.
                if (!ord_full) begin
                    grant_valid = 1'b1;
                    if (mem_addr_ok) begin
                        next_state = ARB_IDLE;
                    end
                end
            end
            ARB_HOLD_D: begin
                grant_src = SRC_DATA;
                if (!ord_full) begin
                    grant_valid = 1'b1;
                    if (mem_addr_ok) begin
                        next_state = ARB_IDLE;
                    end
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // mem_en is forced low while reset is held so a master still asserting
    // its request cannot reach the slave during reset.
    assign mem_en = grant_valid && resetn;
    assign accept = mem_en && mem_addr_ok;

    assign inst_addr_ok = accept && (grant_src == SRC_INST);
    assign data_addr_ok = accept && (grant_src == SRC_DATA);

    // ---------------- request mux ----------------
    always_comb begin
        if (grant_src == SRC_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wen   = data_wen;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wen   = inst_wen;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    // ---------------- ordering FIFO and response routing ----------------
    arb_order_fifo #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .push_src (grant_src),
        .pop      (resp),
        .head_src (ord_head),
        .count    (unused_ord_count),
        .full     (ord_full),
        .empty    (ord_empty)
    );

    // A response with nothing outstanding is stray and dropped.
    assign resp         = mem_data_ok && !ord_empty;
    assign inst_data_ok = resp && (ord_head == SRC_INST);
    assign data_data_ok = resp && (ord_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule
